// File: rtl/decode_hazard_stage.sv
// ---------------------------------------------------------------------------
// decode_hazard_stage
//
// RV32I instruction-decode stage with its ID/EX pipeline register. It takes
// one instruction per cycle from fetch, reads the register file (with an
// optional same-cycle writeback bypass), builds the sign-extended immediate
// and branch target, and hands a registered bundle to execute. A load that is
// followed by an instruction consuming its result holds the consumer for one
// cycle and puts a bubble into ID/EX.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   if_valid_i             fetch presents if_instr_i / if_pc_i
//   if_instr_i, if_pc_i    instruction word and its PC
//   id_ready_o             instruction is accepted this cycle
//   ex_ready_i             execute accepts the ID/EX bundle
//   flush_i                redirect from execute, kills decode and ID/EX
//   wb_we_i/wb_rd_i/wb_data_i  register-file write port
//   idex_*_o               registered bundle towards execute
//   stall_cnt_o            saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module decode_hazard_stage #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_valid_i,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            id_ready_o,
  input  logic            ex_ready_i,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            idex_valid_o,
  output logic [XLEN-1:0] idex_pc_o,
  output logic [XLEN-1:0] idex_rs1_data_o,
  output logic [XLEN-1:0] idex_rs2_data_o,
  output logic [XLEN-1:0] idex_imm_o,
  output logic [XLEN-1:0] idex_pc_branch_o,
  output logic [4:0]      idex_rs1_o,
  output logic [4:0]      idex_rs2_o,
  output logic [4:0]      idex_rd_o,
  output logic            idex_reg_write_o,
  output logic            idex_is_load_o,
  output logic            idex_illegal_o,
  output logic [15:0]     stall_cnt_o
);

  localparam int IDXW = $clog2(NUM_REGS);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pcBranch;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regWrite;
    logic            isLoad;
    logic            illegal;
  } bundle_t;

  logic [XLEN-1:0] regFile_q [NUM_REGS];
  bundle_t         idex_q, idex_d;
  logic            idexValid_q, idexValid_d;
  logic [15:0]     stallCnt_q, stallCnt_d;

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [31:0]     imm32;
  logic [XLEN-1:0] immExt;
  logic            legal, regWriteRaw, usesRs1, usesRs2;
  logic [4:0]      rsIdx  [2];
  logic [XLEN-1:0] rsData [2];
  logic            loadUse, adv, idReady;
  bundle_t         decoded;

  assign opcode   = if_instr_i[6:0];
  assign rd       = if_instr_i[11:7];
  assign rs1      = if_instr_i[19:15];
  assign rs2      = if_instr_i[24:20];
  assign rsIdx[0] = rs1;
  assign rsIdx[1] = rs2;

  // Only 16 or 32 registers exist, so an index is in range unless bit 4 is
  // set on the reduced (RV32E) file.
  function automatic logic inRange(input logic [4:0] idx);
    return (NUM_REGS == 32) || !idx[4];
  endfunction

  // Opcode classification and immediate extraction for the I/S/B/U/J formats.
  always_comb begin
    regWriteRaw = 1'b0;
    legal       = 1'b1;
    usesRs2     = 1'b0;
    imm32       = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        regWriteRaw = 1'b1;
        imm32       = {if_instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        regWriteRaw = 1'b1;
        imm32       = {{12{if_instr_i[31]}}, if_instr_i[19:12], if_instr_i[20],
                       if_instr_i[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        regWriteRaw = 1'b1;
        imm32       = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
      end
      OPC_OP: begin
        regWriteRaw = 1'b1;
        usesRs2     = 1'b1;
      end
      OPC_STORE: begin
        usesRs2 = 1'b1;
        imm32   = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
      end
      OPC_BRANCH: begin
        usesRs2 = 1'b1;
        imm32   = {{20{if_instr_i[31]}}, if_instr_i[7], if_instr_i[30:25],
                   if_instr_i[11:8], 1'b0};
      end
      OPC_FENCE, OPC_SYSTEM: begin
        imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
      end
      default: legal = 1'b0;
    endcase
  end

  assign usesRs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  assign immExt  = XLEN'($signed(imm32));

  // Register read ports; out-of-range indices and x0 read as zero, and the
  // writeback port can be forwarded when it targets the register being read.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rsData[p] = '0;
      if (rsIdx[p] != 5'd0 && inRange(rsIdx[p])) begin
        if (WB_BYPASS && wb_we_i && wb_rd_i == rsIdx[p]) begin
          rsData[p] = wb_data_i;
        end else begin
          rsData[p] = regFile_q[rsIdx[p][IDXW-1:0]];
        end
      end
    end
  end

  // Bundle that would be captured if the instruction is accepted.
  always_comb begin
    decoded          = '0;
    decoded.pc       = if_pc_i;
    decoded.rs1Data  = rsData[0];
    decoded.rs2Data  = rsData[1];
    decoded.imm      = immExt;
    decoded.pcBranch = if_pc_i + immExt;
    decoded.rs1      = rs1;
    decoded.rs2      = rs2;
    decoded.rd       = rd;
    decoded.regWrite = regWriteRaw && legal;
    decoded.isLoad   = (opcode == OPC_LOAD);
    decoded.illegal  = !legal;
  end

  assign loadUse = idexValid_q && idex_q.isLoad && (idex_q.rd != 5'd0) &&
                   ((usesRs1 && rs1 == idex_q.rd) || (usesRs2 && rs2 == idex_q.rd));
  assign adv     = !idexValid_q || ex_ready_i;
  assign idReady = adv && !loadUse && !flush_i && !rst_i;

  // ID/EX next state: flush beats everything, a free slot either loads the
  // accepted instruction or becomes a bubble, otherwise the bundle is held.
  always_comb begin
    idex_d      = idex_q;
    idexValid_d = idexValid_q;
    if (flush_i) begin
      idexValid_d = 1'b0;
    end else if (adv) begin
      if (if_valid_i && idReady) begin
        idex_d      = decoded;
        idexValid_d = 1'b1;
      end else begin
        idexValid_d = 1'b0;
      end
    end
  end

  // Stall counter only counts real stalls; a flushing cycle is not a stall.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (if_valid_i && loadUse && !flush_i && stallCnt_q != 16'hFFFF) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q      <= '0;
      idexValid_q <= 1'b0;
      stallCnt_q  <= '0;
    end else begin
      idex_q      <= idex_d;
      idexValid_q <= idexValid_d;
      stallCnt_q  <= stallCnt_d;
    end
  end

  // Register file write port; x0 and out-of-range targets are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regFile_q[r] <= '0;
      end
    end else if (wb_we_i && wb_rd_i != 5'd0 && inRange(wb_rd_i)) begin
      regFile_q[wb_rd_i[IDXW-1:0]] <= wb_data_i;
    end
  end

  assign id_ready_o       = idReady;
  assign idex_valid_o     = idexValid_q;
  assign idex_pc_o        = idex_q.pc;
  assign idex_rs1_data_o  = idex_q.rs1Data;
  assign idex_rs2_data_o  = idex_q.rs2Data;
  assign idex_imm_o       = idex_q.imm;
  assign idex_pc_branch_o = idex_q.pcBranch;
  assign idex_rs1_o       = idex_q.rs1;
  assign idex_rs2_o       = idex_q.rs2;
  assign idex_rd_o        = idex_q.rd;
  assign idex_reg_write_o = idex_q.regWrite;
  assign idex_is_load_o   = idex_q.isLoad;
  assign idex_illegal_o   = idex_q.illegal;
  assign stall_cnt_o      = stallCnt_q;

endmodule

// File: tb/tb_decode_hazard_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_hazard_stage
//
// Self-checking bench for decode_hazard_stage (XLEN=32, 32 registers, bypass
// on). A behavioural model built from the ISA rules tracks the register file,
// the expected ID/EX bundle and the stall count. Directed vectors carry
// hand-computed expectations; hand-written sequences cover backpressure,
// flush, reset and illegal opcodes; a random phase exercises the rest.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decode_hazard_stage;

  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;
  localparam bit WB_BYPASS = 1'b1;

  logic        clk = 1'b0;
  logic        rst, ifValid, exReady, flush, wbWe;
  logic [31:0] ifInstr, ifPc, wbData;
  logic [4:0]  wbRd;
  logic        idReady, idexValid, idexRegWrite, idexIsLoad, idexIllegal;
  logic [31:0] idexPc, idexRs1Data, idexRs2Data, idexImm, idexPcBranch;
  logic [4:0]  idexRs1, idexRs2, idexRd;
  logic [15:0] stallCnt;

  always #5 clk = ~clk;

  decode_hazard_stage #(
    .XLEN(XLEN), .NUM_REGS(NUM_REGS), .WB_BYPASS(WB_BYPASS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .if_valid_i(ifValid), .if_instr_i(ifInstr),
    .if_pc_i(ifPc), .id_ready_o(idReady), .ex_ready_i(exReady),
    .flush_i(flush), .wb_we_i(wbWe), .wb_rd_i(wbRd), .wb_data_i(wbData),
    .idex_valid_o(idexValid), .idex_pc_o(idexPc),
    .idex_rs1_data_o(idexRs1Data), .idex_rs2_data_o(idexRs2Data),
    .idex_imm_o(idexImm), .idex_pc_branch_o(idexPcBranch),
    .idex_rs1_o(idexRs1), .idex_rs2_o(idexRs2), .idex_rd_o(idexRd),
    .idex_reg_write_o(idexRegWrite), .idex_is_load_o(idexIsLoad),
    .idex_illegal_o(idexIllegal), .stall_cnt_o(stallCnt)
  );

  int checks   = 0;
  int failures = 0;
  bit lastReady;

  typedef struct {
    logic [31:0] pc, rs1Data, rs2Data, imm, pcBranch;
    logic [4:0]  rs1, rs2, rd;
    logic        regWrite, isLoad, illegal;
  } bundle_t;

  // reference model state
  logic [31:0] mRegs [32];
  bundle_t     mIdex;
  bit          mValid = 1'b0;
  bit          mDataKnown = 1'b0;
  int          mStall = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // ---- ISA-level helpers --------------------------------------------------
  function automatic bit isLegal(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33,
                      7'h23, 7'h63, 7'h0F, 7'h73};
  endfunction

  function automatic bit writesRd(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
  endfunction

  function automatic bit readsRs1(input logic [6:0] op);
    return !(op inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic bit readsRs2(input logic [6:0] op);
    return op inside {7'h23, 7'h63, 7'h33};
  endfunction

  // Immediate value as a number: sign from bit 31, fields weighted by position.
  function automatic logic [31:0] immOf(input logic [31:0] ins);
    int s = $signed(ins) >>> 31;
    int v = 0;
    case (ins[6:0])
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: v = $signed(ins) >>> 20;
      7'h23: v = ($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
      7'h63: v = s * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
                 int'(ins[11:8]) * 2;
      7'h37, 7'h17: v = ins & 32'hFFFF_F000;
      7'h6F: v = s * (1 << 20) + int'(ins[19:12]) * (1 << 12) +
                 int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= NUM_REGS) return 32'd0;
    if (WB_BYPASS && wbWe && wbRd == idx) return wbData;
    return mRegs[idx];
  endfunction

  function automatic bundle_t decodeModel(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b;
    logic [6:0] op = ins[6:0];
    b.pc       = pc;
    b.rs1      = ins[19:15];
    b.rs2      = ins[24:20];
    b.rd       = ins[11:7];
    b.rs1Data  = modelRead(b.rs1);
    b.rs2Data  = modelRead(b.rs2);
    b.imm      = immOf(ins);
    b.pcBranch = pc + b.imm;
    b.illegal  = !isLegal(op);
    b.regWrite = writesRd(op) && !b.illegal;
    b.isLoad   = (op == 7'h03);
    return b;
  endfunction

  // ---- encoders -----------------------------------------------------------
  function automatic logic [31:0] encI(input int imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
    logic [11:0] i = imm[11:0];
    return {i, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encR(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] encB(input int imm, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    logic [12:0] b = imm[12:0];
    return {b[12], b[10:5], rs2, rs1, 3'b000, b[4:1], b[11], 7'h63};
  endfunction

  function automatic logic [31:0] encJ(input int imm, input logic [4:0] rd);
    logic [20:0] j = imm[20:0];
    return {j[20], j[10:1], j[11], j[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] encU(input int imm, input logic [4:0] rd,
                                       input logic [6:0] op);
    logic [19:0] u = imm[19:0];
    return {u, rd, op};
  endfunction

  // ---- one clock cycle with model prediction and checks -------------------
  task automatic stepCycle();
    bit lu, adv, rdy;
    logic [6:0] op;
    #2;
    op  = ifInstr[6:0];
    lu  = mValid && mIdex.isLoad && mIdex.rd != 5'd0 &&
          ((readsRs1(op) && ifInstr[19:15] == mIdex.rd) ||
           (readsRs2(op) && ifInstr[24:20] == mIdex.rd));
    adv = !mValid || exReady;
    rdy = !rst && adv && !lu && !flush;
    lastReady = idReady;
    checkOutput("id_ready", idReady, rdy);
    if (rst) begin
      mValid     = 1'b0;
      mIdex      = '{default: '0};
      mDataKnown = 1'b1;
      mStall     = 0;
      foreach (mRegs[r]) mRegs[r] = '0;
    end else begin
      if (ifValid && lu && !flush && mStall < 65535) mStall++;
      if (flush) begin
        mValid     = 1'b0;
        mDataKnown = 1'b0;
      end else if (adv) begin
        if (ifValid && rdy) begin
          mIdex      = decodeModel(ifInstr, ifPc);
          mValid     = 1'b1;
          mDataKnown = 1'b1;
        end else begin
          mValid     = 1'b0;
          mDataKnown = 1'b0;
        end
      end
      if (wbWe && wbRd != 5'd0 && int'(wbRd) < NUM_REGS) mRegs[wbRd] = wbData;
    end
    @(posedge clk);
    #1;
    checkOutput("idex_valid", idexValid, mValid);
    checkOutput("stall_cnt", stallCnt, mStall);
    if (mDataKnown) begin
      checkOutput("idex_pc", idexPc, mIdex.pc);
      checkOutput("idex_rs1_data", idexRs1Data, mIdex.rs1Data);
      checkOutput("idex_rs2_data", idexRs2Data, mIdex.rs2Data);
      checkOutput("idex_imm", idexImm, mIdex.imm);
      checkOutput("idex_pc_branch", idexPcBranch, mIdex.pcBranch);
      checkOutput("idex_fields", {idexRs1, idexRs2, idexRd},
                  {mIdex.rs1, mIdex.rs2, mIdex.rd});
      checkOutput("idex_flags", {idexRegWrite, idexIsLoad, idexIllegal},
                  {mIdex.regWrite, mIdex.isLoad, mIdex.illegal});
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [31:0] ins,
                               input logic [31:0] pc, input bit er, input bit fl,
                               input bit we, input logic [4:0] rd,
                               input logic [31:0] d);
    @(negedge clk);
    rst     = r;
    ifValid = v;
    ifInstr = ins;
    ifPc    = pc;
    exReady = er;
    flush   = fl;
    wbWe    = we;
    wbRd    = rd;
    wbData  = d;
    stepCycle();
  endtask

  // ---- directed vector table ----------------------------------------------
  typedef struct {
    string       name;
    bit          v;
    logic [31:0] ins, pc;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] d;
    bit          expReady, expValid;
    logic [31:0] expRs1, expRs2, expImm, expPcb;
    int          expStall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkVec(input string n, input bit v, input logic [31:0] ins,
                                 input logic [31:0] pc, input bit we,
                                 input logic [4:0] rd, input logic [31:0] d,
                                 input bit eRdy, input bit eVal,
                                 input logic [31:0] e1, input logic [31:0] e2,
                                 input logic [31:0] eImm, input logic [31:0] ePcb,
                                 input int eStall);
    vec_t t;
    t.name = n; t.v = v; t.ins = ins; t.pc = pc; t.we = we; t.rd = rd; t.d = d;
    t.expReady = eRdy; t.expValid = eVal; t.expRs1 = e1; t.expRs2 = e2;
    t.expImm = eImm; t.expPcb = ePcb; t.expStall = eStall;
    return t;
  endfunction

  function automatic logic [6:0] pickOp(input int k);
    case (k)
      0: return 7'h37;  1: return 7'h17;  2: return 7'h6F;  3: return 7'h67;
      4: return 7'h03;  5: return 7'h03;  6: return 7'h13;  7: return 7'h33;
      8: return 7'h23;  9: return 7'h63; 10: return 7'h0F; 11: return 7'h73;
      default: return 7'h7F;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rnd, ins;
    rst = 1'b1; ifValid = 1'b0; ifInstr = '0; ifPc = '0; exReady = 1'b1;
    flush = 1'b0; wbWe = 1'b0; wbRd = '0; wbData = '0;

    tbl.push_back(mkVec("wr_x1", 0, 32'h0, 32'h0, 1, 5'd1, 32'd5, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec("wr_x2", 0, 32'h0, 32'h0, 1, 5'd2, 32'd7, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec("addi_x3", 1, encI(1, 5'd1, 3'd0, 5'd3, 7'h13), 32'h0, 0, 0, 0,
                        1, 1, 32'd5, 32'd5, 32'd1, 32'd1, 0));
    tbl.push_back(mkVec("add_x4", 1, encR(5'd2, 5'd1, 5'd4), 32'h4, 0, 0, 0,
                        1, 1, 32'd5, 32'd7, 32'd0, 32'h4, 0));
    tbl.push_back(mkVec("lw_a", 1, encI(0, 5'd1, 3'd2, 5'd5, 7'h03), 32'h8, 0, 0, 0,
                        1, 1, 32'd5, 32'd0, 32'd0, 32'h8, 0));
    tbl.push_back(mkVec("use_rs1_stall", 1, encR(5'd0, 5'd5, 5'd6), 32'hC, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec("use_rs1_go", 1, encR(5'd0, 5'd5, 5'd6), 32'hC, 0, 0, 0,
                        1, 1, 32'd0, 32'd0, 32'd0, 32'hC, 1));
    tbl.push_back(mkVec("lw_b", 1, encI(0, 5'd1, 3'd2, 5'd5, 7'h03), 32'h10, 0, 0, 0,
                        1, 1, 32'd5, 32'd0, 32'd0, 32'h10, 1));
    tbl.push_back(mkVec("use_rs2_stall", 1, encR(5'd5, 5'd0, 5'd6), 32'h14, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mkVec("use_rs2_go", 1, encR(5'd5, 5'd0, 5'd6), 32'h14, 0, 0, 0,
                        1, 1, 32'd0, 32'd0, 32'd0, 32'h14, 2));
    tbl.push_back(mkVec("lw_c", 1, encI(0, 5'd1, 3'd2, 5'd5, 7'h03), 32'h18, 0, 0, 0,
                        1, 1, 32'd5, 32'd0, 32'd0, 32'h18, 2));
    tbl.push_back(mkVec("lui_nostall", 1, encU(1, 5'd5, 7'h37), 32'h1C, 0, 0, 0,
                        1, 1, 32'd0, 32'd0, 32'h1000, 32'h101C, 2));
    tbl.push_back(mkVec("beq_back", 1, encB(-8, 5'd0, 5'd0), 32'h100, 0, 0, 0,
                        1, 1, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'hF8, 2));
    tbl.push_back(mkVec("jal_fwd", 1, encJ(32'h7FE, 5'd1), 32'h200, 0, 0, 0,
                        1, 1, 32'd0, 32'd0, 32'h7FE, 32'h9FE, 2));
    tbl.push_back(mkVec("bypass_x3", 1, encR(5'd0, 5'd3, 5'd7), 32'h204, 1, 5'd3, 32'hDEAD,
                        1, 1, 32'hDEAD, 32'd0, 32'd0, 32'h204, 2));
    tbl.push_back(mkVec("wr_x0", 0, 32'h0, 32'h0, 1, 5'd0, 32'h1234, 1, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mkVec("read_x0_x3", 1, encR(5'd3, 5'd0, 5'd8), 32'h208, 0, 0, 0,
                        1, 1, 32'd0, 32'hDEAD, 32'd0, 32'h208, 2));

    // reset: outputs and bundle must come out zero
    applyStimulus(1, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, encR(5'd2, 5'd1, 5'd4), 32'h40, 1, 0, 0, 0, 0);
    checkOutput("reset.id_ready", lastReady, 1'b0);

    $display("[TB] directed vectors");
    foreach (tbl[i]) begin
      applyStimulus(0, tbl[i].v, tbl[i].ins, tbl[i].pc, 1, 0, tbl[i].we, tbl[i].rd, tbl[i].d);
      checkOutput({tbl[i].name, ".ready"}, lastReady, tbl[i].expReady);
      checkOutput({tbl[i].name, ".valid"}, idexValid, tbl[i].expValid);
      checkOutput({tbl[i].name, ".stall"}, stallCnt, tbl[i].expStall);
      if (tbl[i].expValid) begin
        checkOutput({tbl[i].name, ".rs1_data"}, idexRs1Data, tbl[i].expRs1);
        checkOutput({tbl[i].name, ".rs2_data"}, idexRs2Data, tbl[i].expRs2);
        checkOutput({tbl[i].name, ".imm"}, idexImm, tbl[i].expImm);
        checkOutput({tbl[i].name, ".pc_branch"}, idexPcBranch, tbl[i].expPcb);
      end
    end

    $display("[TB] backpressure and flush");
    applyStimulus(0, 1, encI(3, 5'd1, 3'd0, 5'd9, 7'h13), 32'h300, 1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 1, encR(5'd2, 5'd1, 5'd10), 32'h304, 0, 0, 0, 0, 0);
      checkOutput("bp.id_ready", lastReady, 1'b0);
      checkOutput("bp.valid", idexValid, 1'b1);
      checkOutput("bp.pc", idexPc, 32'h300);
      checkOutput("bp.imm", idexImm, 32'd3);
      checkOutput("bp.rs1_data", idexRs1Data, 32'd5);
    end
    applyStimulus(0, 1, encR(5'd2, 5'd1, 5'd10), 32'h304, 0, 1, 0, 0, 0);
    checkOutput("flush.id_ready", lastReady, 1'b0);
    checkOutput("flush.valid", idexValid, 1'b0);
    applyStimulus(0, 1, encR(5'd2, 5'd1, 5'd10), 32'h304, 1, 0, 0, 0, 0);
    checkOutput("refetch.pc", idexPc, 32'h304);
    checkOutput("refetch.rs2_data", idexRs2Data, 32'd7);

    $display("[TB] reset mid-stall and illegal opcode");
    applyStimulus(0, 1, encI(0, 5'd1, 3'd2, 5'd5, 7'h03), 32'h400, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, encR(5'd0, 5'd5, 5'd6), 32'h404, 1, 0, 0, 0, 0);
    checkOutput("stall.stall_cnt", stallCnt, 32'd3);
    applyStimulus(1, 1, encR(5'd0, 5'd5, 5'd6), 32'h404, 1, 0, 0, 0, 0);
    checkOutput("rst.id_ready", lastReady, 1'b0);
    checkOutput("rst.valid", idexValid, 1'b0);
    checkOutput("rst.stall_cnt", stallCnt, 32'd0);
    checkOutput("rst.bundle", {idexPc, idexImm, idexRs1Data, idexRd, idexIsLoad}, 64'd0);
    applyStimulus(0, 1, encR(5'd2, 5'd1, 5'd11), 32'h500, 1, 0, 0, 0, 0);
    checkOutput("rst.regs_cleared", {idexRs1Data, idexRs2Data}, 64'd0);
    applyStimulus(0, 1, 32'h0000_037F, 32'h504, 1, 0, 0, 0, 0);
    checkOutput("illegal.flag", idexIllegal, 1'b1);
    checkOutput("illegal.reg_write", idexRegWrite, 1'b0);

    $display("[TB] random stimulus");
    for (int r = 1; r < 8; r++) begin
      rnd = $urandom;
      applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 1, 5'(r), rnd);
    end
    for (int n = 0; n < 600; n++) begin
      rnd = $urandom;
      ins = rnd;
      ins[6:0] = pickOp($urandom_range(0, 13));
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                              : 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      rnd = $urandom;
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, ins,
                    rnd & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_hazard_stage.md
# decode_hazard_stage

Parametrised instruction-decode stage with an integrated ID/EX pipeline register, load-use hazard detection, flush, and valid/ready handshaking on both sides. It sits between fetch and execute: it accepts one RV32I instruction per cycle from fetch, reads the register file with writeback bypass, and generates the sign-extended immediate and branch target. It presents a registered bundle to execute, inserting a one-cycle bubble on load-use hazards.

## Interface
- XLEN, 32, datapath width; allowed values are 32 or 64.
- NUM_REGS, 32, architectural register count; allowed values are 16 (RV32E) or 32. Register indices at or above NUM_REGS read as 0 and are never written.
- WB_BYPASS, 1, when set, a same-cycle writeback to rs1 or rs2 is forwarded to the read data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  PC of if_instr.
- id_ready  out  1  the stage accepts if_instr this cycle.
- ex_ready  in  1  execute accepts the ID/EX bundle.
- flush  in  1  redirect from execute; kills in-flight decode and ID/EX contents.
- wb_we, wb_rd[4:0], wb_data[XLEN]  in  register-file write port.
- idex_valid  out  1  the bundle is valid.
- idex_pc, idex_rs1_data, idex_rs2_data, idex_imm, idex_pc_branch  out  XLEN each.
- idex_rs1, idex_rs2, idex_rd  out  5 each.
- idex_reg_write, idex_is_load, idex_illegal  out  1 each.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

## Operation
- Register file: NUM_REGS×XLEN. x0 always reads 0. Write occurs when wb_we and wb_rd is non-zero and wb_rd < NUM_REGS. Reads are combinational.
- Writeback bypass: when WB_BYPASS is set and wb_we is high with wb_rd equal to a non-zero rs, the read returns wb_data.
- Immediate: I/S/B/U/J formats are selected by opcode and sign-extended to XLEN. B and J immediates already contain bit0=0, so there is no extra shift. idex_pc_branch = pc + imm, mod 2^XLEN.
- reg_write is set for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP. is_load is set for opcode 0000011.
- illegal is set for any other opcode except STORE, BRANCH, FENCE and SYSTEM. An illegal instruction has reg_write forced to 0 but still passes downstream.
- uses_rs1 is set for all opcodes except LUI, AUIPC and JAL. uses_rs2 is set for STORE, BRANCH and OP.
- load_use = idex_valid & idex_is_load & (idex_rd≠0) & ((uses_rs1 & rs1==idex_rd) | (uses_rs2 & rs2==idex_rd)).
- adv = !idex_valid | ex_ready.
- id_ready = adv & !load_use & !flush.
- ID/EX update, in priority order:
  - flush: idex_valid←0.
  - else if adv: if if_valid & id_ready, load the bundle and set idex_valid←1; otherwise idex_valid←0 (bubble).
  - else: hold all idex_* outputs unchanged.
- stall_cnt increments on each cycle with if_valid & load_use & !flush, and saturates at 0xFFFF.

## Timing
- Latency: an instruction accepted in cycle N (if_valid & id_ready) appears on idex_* in cycle N+1.
- Throughput: one instruction per cycle with no hazard.
- Load-use: exactly one bubble. In cycle N the load sits in ID/EX and the dependent instruction is held with id_ready=0. The load leaves at the end of N (given ex_ready). In N+1 the bubble occupies ID/EX and the dependent instruction is accepted. It appears at N+2.
- Backpressure: while idex_valid & !ex_ready, idex_* are stable and id_ready=0.
- Flush: takes effect at the next edge. An instruction presented in the flush cycle is not accepted.
- Flush and load_use together: flush wins, and stall_cnt does not increment.
- Writeback to a register read in the same cycle:
  - WB_BYPASS=1: the new value is captured.
  - WB_BYPASS=0: the old value is captured.
- Reset, while rst is high and at the next edge:
  - idex_valid=0 and all idex_* data and fields = 0.
  - All registers = 0.
  - stall_cnt = 0.
  - id_ready = 0.
- Reset mid-stream discards the ID/EX contents. No partial bundle survives.

## Test plan
- Back-to-back ADDI. After writing x1=5 and x2=7, stream `addi x3,x1,1` then `add x4,x1,x2`. Required: idex_rs1_data=5 then 5, idex_rs2_data=7, idex_imm=1 then 0, with no id_ready drop.
- Load-use. `lw x5,0(x1)` followed by `add x6,x5,x0`. Required: id_ready=0 for exactly one cycle, one idex_valid=0 bubble, and stall_cnt increments by 1. A following `add x6,x0,x5` (the rs2 case) gives the same response. `lui x5,1` after the lw gives no stall.
- Branch target. A BEQ at pc=0x100 with imm=-8 gives idex_pc_branch=0xF8. A JAL with imm=0x7FE gives pc+0x7FE.
- Backpressure and flush. Hold ex_ready=0 for 3 cycles: idex_* stay constant and id_ready=0. Then assert flush with if_valid=1: the next cycle has idex_valid=0 and the instruction is not consumed.
- Bypass and x0. With wb_we=1, wb_rd=3, wb_data=0xDEAD in the same cycle as decoding `add x7,x3,x0`: idex_rs1_data=0xDEAD (WB_BYPASS=1). A write to x0 leaves x0 reading 0.
- Reset and illegal opcode. Assert rst mid-stall: all outputs zero and stall_cnt=0. After reset, opcode 0x7F gives idex_illegal=1 and idex_reg_write=0.
